dht_single_wire_ctrl: RTL and testbench

//  Parametrised single-wire controller for DHT-family humidity/temperature sensors.
//  Per request: drives the host start pulse, checks the sensor response, decodes the

---
 rtl/dht_single_wire_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dht_single_wire_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht_single_wire_ctrl.sv
// Single-wire DHT-family sensor controller: start pulse, response check, pulse-width bit decode, checksum.
// Latency: one full sensor transaction per start; dq_in edges seen 3 cycles late (5 with the glitch filter).
// Backpressure: none; start is taken only in IDLE and ignored while busy or in the FINISH cycle.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle request, honoured only in IDLE
//   dq_in           raw DQ pad level (asynchronous to clk)
//   dq_oe           1 = pull DQ low (only during the start pulse), 0 = release
//   busy / done     busy from the cycle after start; done is a one-cycle end-of-transaction pulse
//   data_out        received frame, MSB first; partial frame kept on error
//   chk_ok          byte-sum of all but the last byte (mod 256) equals the last byte, and no error
//   err             0 none, 1 no sensor response, 2 bit timeout
// Build option: define DQ_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchroniser.
module dht_single_wire_ctrl #(
   parameter int CLK_PER_US    = 1,
   parameter int START_LOW_US  = 18000,
   parameter int RELEASE_US    = 30,
   parameter int RESP_TO_US    = 100,
   parameter int BIT_TO_US     = 100,
   parameter int BIT_THRESH_US = 48,
   parameter int NBITS         = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dq_in,
   output logic             dq_oe,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] data_out,
   output logic             chk_ok,
   output logic [1:0]       err
);

   localparam int CW     = $clog2(START_LOW_US*CLK_PER_US+1);
   localparam int BW     = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int NBYTES = NBITS/8;

   // Terminal counts: a phase times out after exactly N cycles spent in the state.
   localparam logic [CW-1:0] C_START  = CW'(START_LOW_US*CLK_PER_US - 1);
   localparam logic [CW-1:0] C_REL    = CW'((RELEASE_US+RESP_TO_US)*CLK_PER_US - 1);
   localparam logic [CW-1:0] C_RESP   = CW'(RESP_TO_US*CLK_PER_US - 1);
   localparam logic [CW-1:0] C_BIT    = CW'(BIT_TO_US*CLK_PER_US - 1);
   localparam logic [CW-1:0] C_THRESH = CW'(BIT_THRESH_US*CLK_PER_US);
   localparam logic [CW-1:0] C_MAX    = '1;
   localparam logic [BW-1:0] C_LAST   = BW'(NBITS-1);

   typedef enum logic [2:0] {
      S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_FINISH
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [BW-1:0]    r_bit;
   logic [NBITS-1:0] r_shift;
   logic [1:0]       r_sync;
   logic             r_prev;
   logic             w_lvl;
   logic             w_rise;
   logic             w_fall;
   logic [CW-1:0]    w_cnt_inc;
   logic [7:0]       w_sum;
   logic             w_sum_match;

   // Sync registers reset to 1 (idle bus level) so reset release never fakes a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], dq_in};
   end

`ifdef DQ_GLITCH_FILTER_EN
   logic [1:0] r_hist;
   logic       r_filt;

   // Majority of three consecutive samples: a single-cycle pulse never wins the vote.
   // Both edges are delayed equally, so measured pulse widths are unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= 2'b11;
         r_filt <= 1'b1;
      end else begin
         r_hist <= {r_hist[0], r_sync[1]};
         r_filt <= (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);
      end
   end
   assign w_lvl = r_filt;
`else
   assign w_lvl = r_sync[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_prev <= 1'b1;
      else     r_prev <= w_lvl;
   end

   assign w_rise    = w_lvl & ~r_prev;
   assign w_fall    = ~w_lvl & r_prev;
   assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;

   // Checksum byte sits in the LSBs; sum every other byte mod 256.
   always_comb begin
      w_sum = '0;
      for (int i = 1; i < NBYTES; i++) w_sum = w_sum + r_shift[i*8 +: 8];
   end
   assign w_sum_match = (w_sum == r_shift[7:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         dq_oe    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         chk_ok   <= 1'b0;
         err      <= 2'd0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  err     <= 2'd0;
                  chk_ok  <= 1'b0;
                  r_shift <= '0;
                  r_cnt   <= '0;
                  dq_oe   <= 1'b1;
                  busy    <= 1'b1;
                  r_state <= S_START_LOW;
               end
            end
            S_START_LOW: begin
               if (r_cnt == C_START) begin
                  dq_oe   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_RELEASE;
               end else r_cnt <= w_cnt_inc;
            end
            S_RELEASE: begin
               if (w_fall) begin
                  r_cnt   <= '0;
                  r_state <= S_RESP_LOW;
               end else if (r_cnt >= C_REL) begin
                  err     <= 2'd1;
                  r_state <= S_FINISH;
               end else r_cnt <= w_cnt_inc;
            end
            S_RESP_LOW: begin
               if (w_rise) begin
                  r_cnt   <= '0;
                  r_state <= S_RESP_HIGH;
               end else if (r_cnt >= C_RESP) begin
                  err     <= 2'd1;
                  r_state <= S_FINISH;
               end else r_cnt <= w_cnt_inc;
            end
            S_RESP_HIGH: begin
               if (w_fall) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= S_BIT_LOW;
               end else if (r_cnt >= C_RESP) begin
                  err     <= 2'd1;
                  r_state <= S_FINISH;
               end else r_cnt <= w_cnt_inc;
            end
            S_BIT_LOW: begin
               if (w_rise) begin
                  r_cnt   <= '0;
                  r_state <= S_BIT_HIGH;
               end else if (r_cnt >= C_BIT) begin
                  err     <= 2'd2;
                  r_state <= S_FINISH;
               end else r_cnt <= w_cnt_inc;
            end
            S_BIT_HIGH: begin
               if (w_fall) begin
                  // Long high pulse decodes as 1; no wait for the sensor's trailing release.
                  r_shift <= {r_shift[NBITS-2:0], (r_cnt > C_THRESH)};
                  r_cnt   <= '0;
                  if (r_bit == C_LAST) r_state <= S_FINISH;
                  else begin
                     r_bit   <= r_bit + 1'b1;
                     r_state <= S_BIT_LOW;
                  end
               end else if (r_cnt >= C_BIT) begin
                  err     <= 2'd2;
                  r_state <= S_FINISH;
               end else r_cnt <= w_cnt_inc;
            end
            S_FINISH: begin
               data_out <= r_shift;
               chk_ok   <= (err == 2'd0) && w_sum_match;
               done     <= 1'b1;
               busy     <= 1'b0;
               r_cnt    <= '0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dht_single_wire_ctrl.sv
module tb_dht_single_wire_ctrl;
   localparam int NB = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          dq_in;
   logic          dq_oe;
   logic          busy;
   logic          done;
   logic [NB-1:0] data_out;
   logic          chk_ok;
   logic [1:0]    err;
   logic          s_drv;     // sensor side: 0 = pull low, 1 = released (pull-up)

   int checks   = 0;
   int failures = 0;
   int s_bit    = -1;
   bit s_high   = 1'b0;

   assign dq_in = dq_oe ? 1'b0 : s_drv;

   always #5 clk = ~clk;

   dht_single_wire_ctrl #(
      .CLK_PER_US(1), .START_LOW_US(1000), .RELEASE_US(30), .RESP_TO_US(100),
      .BIT_TO_US(100), .BIT_THRESH_US(48), .NBITS(NB)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .dq_in(dq_in), .dq_oe(dq_oe),
      .busy(busy), .done(done), .data_out(data_out), .chk_ok(chk_ok), .err(err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Sensor model: waits for the host start pulse, answers 80/80, then sends bits as
   // 50-cycle low + 26 (0) or 70 (1) high. stall_at: bit index whose high phase never ends.
   // glitch_bit: a '1' bit that gets a 1-cycle low glitch in the middle of its high phase.
   task automatic sensor(input logic [NB-1:0] frame, input int stall_at, input int glitch_bit);
      bit ok;
      s_bit = -1; s_high = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (dq_oe) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin check("sensor_saw_start", 0, 1); return; end
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (!dq_oe) begin ok = 1'b1; break; end
      end
      if (!ok) begin check("sensor_saw_release", 0, 1); return; end
      repeat (20) @(negedge clk);
      s_drv = 1'b0; repeat (80) @(negedge clk);
      s_drv = 1'b1; repeat (80) @(negedge clk);
      for (int b = 0; b < NB; b++) begin
         s_bit = b; s_high = 1'b0;
         s_drv = 1'b0; repeat (50) @(negedge clk);
         s_drv = 1'b1; s_high = 1'b1;
         if (b == stall_at) return;
         if (frame[NB-1-b]) begin
            if (b == glitch_bit) begin
               repeat (35) @(negedge clk);
               s_drv = 1'b0; @(negedge clk);
               s_drv = 1'b1; repeat (34) @(negedge clk);
            end else repeat (70) @(negedge clk);
         end else repeat (26) @(negedge clk);
      end
      s_high = 1'b0;
      s_drv = 1'b0; repeat (50) @(negedge clk);
      s_drv = 1'b1;
      s_bit = -1;
   endtask

   task automatic wait_done(input string name, output int n);
      bit got;
      got = 1'b0;
      n = 0;
      for (int i = 0; i < 15000; i++) begin
         @(negedge clk);
         n++;
         if (done) begin got = 1'b1; break; end
      end
      check({name, "_done_seen"}, got, 1);
      if (got) begin
         @(negedge clk);
         check({name, "_done_one_pulse"}, done, 0);
      end
   endtask

   typedef struct {
      string         name;
      logic [NB-1:0] frame;
      int            stall_at;
      logic [NB-1:0] exp_data;
      logic          exp_chk;
      logic [1:0]    exp_err;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int n;
      int cnt;

      tbl[0] = '{"good",     40'h350018004D, -1, 40'h350018004D, 1'b1, 2'd0};
      tbl[1] = '{"badsum",   40'h350018004E, -1, 40'h350018004E, 1'b0, 2'd0};
      tbl[2] = '{"wrapsum",  40'hFFFF0000FE, -1, 40'hFFFF0000FE, 1'b1, 2'd0};
      tbl[3] = '{"small",    40'h010203040A, -1, 40'h010203040A, 1'b1, 2'd0};
      tbl[4] = '{"stall13",  40'h350018004D, 13, 40'h00000006A0, 1'b0, 2'd2};

      rst = 1'b1; start = 1'b0; s_drv = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dq_oe", dq_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", data_out, 0);
      check("rst_chk", chk_ok, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         pulse_start();
         check({tbl[v].name, "_busy"}, busy, 1);
         fork
            sensor(tbl[v].frame, tbl[v].stall_at, -1);
            wait_done(tbl[v].name, n);
         join
         check({tbl[v].name, "_data"}, data_out, tbl[v].exp_data);
         check({tbl[v].name, "_chk"}, chk_ok, tbl[v].exp_chk);
         check({tbl[v].name, "_err"}, err, tbl[v].exp_err);
         check({tbl[v].name, "_idle"}, busy, 0);
         s_drv = 1'b1;
         repeat (200) @(negedge clk);
      end

      // No sensor: start pulse length, then response timeout.
      pulse_start();
      cnt = 0;
      for (int i = 0; i < 20000; i++) begin
         if (!dq_oe) break;
         cnt++;
         @(negedge clk);
      end
      check("nosensor_low_cycles", cnt, 1000);
      wait_done("nosensor", n);
      check("nosensor_release_to_done", (n >= 128 && n <= 134), 1);
      check("nosensor_err", err, 1);
      check("nosensor_chk", chk_ok, 0);
      repeat (20) @(negedge clk);

      // start re-pulsed in the middle of a read must not disturb it.
      pulse_start();
      fork
         sensor(40'h350018004D, -1, -1);
         wait_done("repulse", n);
         begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20000; i++) begin
               @(negedge clk);
               if (s_bit == 10) begin ok = 1'b1; break; end
            end
            check("repulse_reached", ok, 1);
            start = 1'b1; @(negedge clk); start = 1'b0;
            check("repulse_busy", busy, 1);
            check("repulse_no_drive", dq_oe, 0);
         end
      join
      check("repulse_data", data_out, 40'h350018004D);
      check("repulse_chk", chk_ok, 1);
      check("repulse_err", err, 0);
      repeat (200) @(negedge clk);

      // Glitch inside the high phase of bit 2 (a '1').
      pulse_start();
      fork
         sensor(40'h350018004D, -1, 2);
         wait_done("glitch", n);
      join
`ifdef DQ_GLITCH_FILTER_EN
      check("glitch_filtered_data", data_out, 40'h350018004D);
      check("glitch_filtered_err", err, 0);
      check("glitch_filtered_chk", chk_ok, 1);
`else
      check("glitch_unfiltered_corrupt", (err != 2'd0) || (data_out != 40'h350018004D), 1);
      check("glitch_unfiltered_chk", chk_ok, 0);
`endif
      repeat (200) @(negedge clk);

      // Asynchronous reset while the controller is measuring a high bit.
      pulse_start();
      fork
         sensor(40'h350018004D, -1, -1);
         begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20000; i++) begin
               @(negedge clk);
               if (s_bit == 5 && s_high) begin ok = 1'b1; break; end
            end
            check("rst_mid_reached", ok, 1);
            repeat (20) @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst_mid_dq_oe", dq_oe, 0);
            check("rst_mid_busy", busy, 0);
            check("rst_mid_data", data_out, 0);
            check("rst_mid_err", err, 0);
            check("rst_mid_done", done, 0);
            @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (50) @(negedge clk);
      check("rst_after_busy", busy, 0);
      check("rst_after_data", data_out, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
